// File: rtl/dso_acq_pkg.sv
// Shared types for the DSO acquisition sequencer.
// State codes are visible to the OSD through acq_state.
package dso_acq_pkg;

   typedef enum logic [2:0] {
      ARM       = 3'd0,
      WAIT_TRIG = 3'd1,
      POST      = 3'd2,
      DONE      = 3'd3,
      STOPPED   = 3'd4
   } acq_state_t;

   typedef enum logic [1:0] {
      MODE_AUTO   = 2'd0,
      MODE_NORMAL = 2'd1,
      MODE_SINGLE = 2'd2
   } mode_t;

   localparam int OFS_W = 10;

   // Code 3 is reserved and behaves as NORMAL.
   function automatic mode_t decode_mode(input logic [1:0] m);
      mode_t r;
      case (m)
         2'd0:    r = MODE_AUTO;
         2'd2:    r = MODE_SINGLE;
         default: r = MODE_NORMAL;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/dso_acq_if.sv
// Control/sampler/display bundle around the acquisition sequencer.
// master = sequencer side, slave = sampler/user/display side.
interface dso_acq_if;
   import dso_acq_pkg::*;

   logic [1:0]       trig_mode;
   logic             run_key;
   logic             single_key;
   logic             ad_buf_wr;
   logic             ad_sample_trig;
   logic [OFS_W-1:0] ad_sample_offset;
   logic             disp_done;
   logic             wave_run;
   logic             wr_over;
   logic             force_trig;
   logic             frame_valid;
   logic [OFS_W-1:0] frame_trig_offset;
   logic             frame_auto;
   logic [2:0]       acq_state;

   modport master (
      input  trig_mode, run_key, single_key, ad_buf_wr,
      input  ad_sample_trig, ad_sample_offset, disp_done,
      output wave_run, wr_over, force_trig, frame_valid,
      output frame_trig_offset, frame_auto, acq_state
   );

   modport slave (
      output trig_mode, run_key, single_key, ad_buf_wr,
      output ad_sample_trig, ad_sample_offset, disp_done,
      input  wave_run, wr_over, force_trig, frame_valid,
      input  frame_trig_offset, frame_auto, acq_state
   );

endinterface

// File: rtl/dso_acq_timer.sv
// Saturating timeout counter; tc fires once per clear at LIMIT-1.
module dso_acq_timer #(
   parameter int LIMIT = 5000000
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic tc
);
   localparam int TW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
   localparam logic [TW-1:0] LAST = TW'(LIMIT - 1);
   localparam logic [TW-1:0] MAXV = '1;

   logic [TW-1:0] count;
   logic          hit;

   assign tc = en && !clr && !hit && (count == LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
         hit   <= 1'b0;
      end else if (clr) begin
         count <= '0;
         hit   <= 1'b0;
      end else if (en) begin
         if (count != MAXV) count <= count + 1'b1;
         if (tc) hit <= 1'b1;
      end
   end

endmodule

// File: rtl/dso_acq_ctrl.sv
// Acquisition sequencer: arm / wait-trigger / post-fill / hand-off,
// with AUTO forced triggers and frame-boundary run/stop.
module dso_acq_ctrl
   import dso_acq_pkg::*;
#(
   parameter int WAVE_DEPTH   = 1024,
   parameter int HALF_DEPTH   = WAVE_DEPTH >> 1,
   parameter int AUTO_TIMEOUT = 5000000,
   parameter bit RUN_AT_RESET = 1'b1
) (
   input logic       ad_clk,
   input logic       rst,
   dso_acq_if.master bus
);
   localparam logic [10:0] HALF = 11'(HALF_DEPTH);

   acq_state_t  state;
   mode_t       mode;
   logic        mode_ld;
   logic        stop_pend;
   logic        forced;
   logic [10:0] cnt;
   logic [10:0] cnt_inc;
   logic        tmr_tc;
   logic        stop_now;

   assign cnt_inc  = (cnt == HALF) ? cnt : cnt + 11'd1;
   assign stop_now = stop_pend ^ bus.run_key;
   assign bus.acq_state = state;

   dso_acq_timer #(.LIMIT(AUTO_TIMEOUT)) u_timer (
      .clk (ad_clk),
      .rst (rst),
      .clr (state != WAIT_TRIG),
      .en  (state == WAIT_TRIG),
      .tc  (tmr_tc)
   );

   always_ff @(posedge ad_clk or posedge rst) begin
      if (rst) begin
         state                 <= RUN_AT_RESET ? ARM : STOPPED;
         mode                  <= MODE_NORMAL;
         mode_ld               <= 1'b1;
         stop_pend             <= 1'b0;
         forced                <= 1'b0;
         cnt                   <= '0;
         bus.wave_run          <= RUN_AT_RESET;
         bus.wr_over           <= 1'b0;
         bus.force_trig        <= 1'b0;
         bus.frame_valid       <= 1'b0;
         bus.frame_trig_offset <= '0;
         bus.frame_auto        <= 1'b0;
      end else begin
         bus.wr_over    <= 1'b0;
         bus.force_trig <= 1'b0;
         if (bus.run_key && state != STOPPED) stop_pend <= ~stop_pend;
         unique case (state)
            ARM: begin
               bus.wave_run <= 1'b1;
               if (mode_ld) begin
                  mode    <= decode_mode(bus.trig_mode);
                  mode_ld <= 1'b0;
               end
               if (bus.ad_buf_wr) begin
                  if (cnt_inc == HALF) begin
                     cnt    <= '0;
                     forced <= 1'b0;
                     state  <= WAIT_TRIG;
                  end else cnt <= cnt_inc;
               end
            end
            WAIT_TRIG: begin
               // A real trigger beats a same-cycle timeout.
               if (bus.ad_sample_trig) begin
                  bus.frame_auto        <= forced;
                  bus.frame_trig_offset <= forced ? '0 : bus.ad_sample_offset;
                  state                 <= POST;
               end else if (mode == MODE_AUTO && tmr_tc) begin
                  bus.force_trig <= 1'b1;
                  forced         <= 1'b1;
               end
            end
            POST: begin
               if (bus.ad_buf_wr) begin
                  if (cnt_inc == HALF) begin
                     cnt             <= '0;
                     bus.frame_valid <= 1'b1;
                     state           <= DONE;
                  end else cnt <= cnt_inc;
               end
            end
            DONE: begin
               if (bus.disp_done) begin
                  stop_pend <= 1'b0;
                  if (stop_now || mode == MODE_SINGLE) begin
                     bus.wave_run <= 1'b0;
                     state        <= STOPPED;
                  end else begin
                     bus.wr_over     <= 1'b1;
                     bus.wave_run    <= 1'b1;
                     bus.frame_valid <= 1'b0;
                     mode_ld         <= 1'b1;
                     state           <= ARM;
                  end
               end
            end
            STOPPED: begin
               bus.wave_run <= 1'b0;
               if (bus.run_key || bus.single_key) begin
                  bus.wr_over     <= 1'b1;
                  bus.wave_run    <= 1'b1;
                  bus.frame_valid <= 1'b0;
                  stop_pend       <= 1'b0;
                  cnt             <= '0;
                  state           <= ARM;
                  if (bus.single_key) begin
                     mode    <= MODE_SINGLE;
                     mode_ld <= 1'b0;
                  end else mode_ld <= 1'b1;
               end
            end
            default: state <= STOPPED;
         endcase
      end
   end

endmodule

// File: tb/tb_dso_acq_ctrl.sv
// Randomized scenario bench for dso_acq_ctrl against frame-level rules.
// Expectations come from strobe counts, timeouts and key history.
module tb_dso_acq_ctrl;
   localparam int HALF = 512;
   localparam int TMO  = 100;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   bad = 0;
   int   nforce = 0;

   always #5 clk = ~clk;

   dso_acq_if bus();
   dso_acq_if bus0();

   dso_acq_ctrl #(.WAVE_DEPTH(1024), .AUTO_TIMEOUT(TMO), .RUN_AT_RESET(1'b1))
      dut (.ad_clk(clk), .rst(rst), .bus(bus));

   dso_acq_ctrl #(.WAVE_DEPTH(1024), .AUTO_TIMEOUT(TMO), .RUN_AT_RESET(1'b0))
      dut0 (.ad_clk(clk), .rst(rst), .bus(bus0));

   always @(negedge clk) if (!rst && bus.force_trig) nforce++;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         repeat ($urandom_range(0, 2)) tick();
         bus.ad_buf_wr = 1'b1;
         tick();
         bus.ad_buf_wr = 1'b0;
      end
   endtask

   task automatic trig(input logic [9:0] off);
      bus.ad_sample_offset = off;
      bus.ad_sample_trig   = 1'b1;
      tick();
      bus.ad_sample_trig   = 1'b0;
   endtask

   task automatic disp();
      bus.disp_done = 1'b1;
      tick();
      bus.disp_done = 1'b0;
   endtask

   task automatic runk();
      bus.run_key = 1'b1;
      tick();
      bus.run_key = 1'b0;
   endtask

   task automatic frame(input string tag, input logic [9:0] off);
      feed(HALF);
      chk({tag, "_wait"}, bus.acq_state, 1);
      trig(off);
      chk({tag, "_post"}, bus.acq_state, 2);
      feed(HALF);
      chk({tag, "_done"}, bus.acq_state, 3);
      chk({tag, "_fv"}, bus.frame_valid, 1);
      chk({tag, "_ofs"}, bus.frame_trig_offset, off);
   endtask

   initial begin
      logic [9:0] off;
      int k;
      bus.trig_mode = 2'd1;
      bus.run_key = 0; bus.single_key = 0; bus.ad_buf_wr = 0;
      bus.ad_sample_trig = 0; bus.ad_sample_offset = 0; bus.disp_done = 0;
      bus0.trig_mode = 2'd1;
      bus0.run_key = 0; bus0.single_key = 0; bus0.ad_buf_wr = 0;
      bus0.ad_sample_trig = 0; bus0.ad_sample_offset = 0; bus0.disp_done = 0;
      repeat (3) tick();
      chk("rst_run", bus.wave_run, 1);
      chk("rst_wro", bus.wr_over, 0);
      chk("rst_frc", bus.force_trig, 0);
      chk("rst_fv", bus.frame_valid, 0);
      chk("rst_ofs", bus.frame_trig_offset, 0);
      chk("rst_auto", bus.frame_auto, 0);
      chk("rst_st", bus.acq_state, 0);
      chk("rst0_st", bus0.acq_state, 4);
      chk("rst0_run", bus0.wave_run, 0);
      rst = 1'b0;
      tick();

      bus0.run_key = 1'b1;
      tick();
      bus0.run_key = 1'b0;
      chk("r0_wro", bus0.wr_over, 1);
      chk("r0_st", bus0.acq_state, 0);
      chk("r0_run", bus0.wave_run, 1);
      tick();
      chk("r0_wro_end", bus0.wr_over, 0);

      // NORMAL frame; a long trigger wait must not force anything
      feed(HALF - 1);
      chk("n_arm", bus.acq_state, 0);
      feed(1);
      chk("n_wait", bus.acq_state, 1);
      repeat ($urandom_range(TMO + 1, 3 * TMO)) tick();
      chk("n_nofrc", nforce, 0);
      trig(10'd37);
      chk("n_post", bus.acq_state, 2);
      feed(HALF - 1);
      chk("n_fv0", bus.frame_valid, 0);
      feed(1);
      chk("n_done", bus.acq_state, 3);
      chk("n_fv", bus.frame_valid, 1);
      chk("n_ofs", bus.frame_trig_offset, 37);
      chk("n_auto", bus.frame_auto, 0);
      bus.trig_mode = 2'd0;
      disp();
      chk("n_wro", bus.wr_over, 1);
      chk("n_arm2", bus.acq_state, 0);
      chk("n_fvclr", bus.frame_valid, 0);
      tick();
      chk("n_wro_end", bus.wr_over, 0);

      // AUTO: forced trigger exactly TMO cycles after WAIT_TRIG entry
      feed(HALF);
      chk("a_wait", bus.acq_state, 1);
      k = 0;
      while (k < 3 * TMO) begin
         tick();
         k++;
         if (bus.force_trig) break;
      end
      chk("a_delay", k, TMO);
      tick();
      chk("a_frc_end", bus.force_trig, 0);
      repeat ($urandom_range(0, 5)) tick();
      off = 10'($urandom_range(1, 1023));
      trig(off);
      feed(HALF);
      chk("a_done", bus.acq_state, 3);
      chk("a_auto", bus.frame_auto, 1);
      chk("a_ofs", bus.frame_trig_offset, 0);

      // trigger in ARM ignored; trigger coinciding with timeout wins
      disp();
      trig(10'd5);
      chk("c_armtrig", bus.acq_state, 0);
      feed(HALF);
      repeat (TMO - 1) tick();
      off = 10'($urandom_range(1, 1023));
      trig(off);
      chk("c_post", bus.acq_state, 2);
      chk("c_nofrc", bus.force_trig, 0);
      tick();
      chk("c_nofrc2", bus.force_trig, 0);
      feed(HALF);
      chk("c_auto", bus.frame_auto, 0);
      chk("c_ofs", bus.frame_trig_offset, off);
      chk("c_count", nforce, 1);

      // stop request during POST lands at the frame boundary
      bus.trig_mode = 2'd1;
      disp();
      feed(HALF);
      off = 10'($urandom_range(0, 1023));
      trig(off);
      feed(200);
      runk();
      feed(HALF - 200);
      chk("s_done", bus.acq_state, 3);
      disp();
      chk("s_st", bus.acq_state, 4);
      chk("s_wro", bus.wr_over, 0);
      chk("s_run", bus.wave_run, 0);
      chk("s_fv", bus.frame_valid, 1);
      runk();
      chk("s_wro2", bus.wr_over, 1);
      chk("s_arm", bus.acq_state, 0);
      chk("s_run2", bus.wave_run, 1);

      // two run_keys cancel the stop
      feed(HALF);
      runk();
      off = 10'($urandom_range(0, 1023));
      trig(off);
      runk();
      feed(HALF);
      bus.trig_mode = 2'd2;
      disp();
      chk("x_wro", bus.wr_over, 1);
      chk("x_arm", bus.acq_state, 0);

      // SINGLE mode, then single_key re-arm
      off = 10'($urandom_range(0, 1023));
      frame("g", off);
      disp();
      chk("g_st", bus.acq_state, 4);
      chk("g_run", bus.wave_run, 0);
      chk("g_fv", bus.frame_valid, 1);
      chk("g_keep", bus.frame_trig_offset, off);
      bus.trig_mode = 2'd1;
      repeat ($urandom_range(1, 10)) tick();
      bus.single_key = 1'b1;
      tick();
      bus.single_key = 1'b0;
      chk("g_wro", bus.wr_over, 1);
      chk("g_arm", bus.acq_state, 0);
      chk("g_fv0", bus.frame_valid, 0);
      off = 10'($urandom_range(0, 1023));
      frame("h", off);
      disp();
      chk("h_st", bus.acq_state, 4);

      // asynchronous reset in the middle of POST
      runk();
      off = 10'($urandom_range(1, 1023));
      frame("p", off);
      disp();
      feed(HALF);
      trig(off);
      feed(100);
      #2 rst = 1'b1;
      tick();
      chk("r_run", bus.wave_run, 1);
      chk("r_wro", bus.wr_over, 0);
      chk("r_fv", bus.frame_valid, 0);
      chk("r_ofs", bus.frame_trig_offset, 0);
      chk("r_auto", bus.frame_auto, 0);
      chk("r_st", bus.acq_state, 0);
      chk("r0_st2", bus0.acq_state, 4);
      chk("r0_run2", bus0.wave_run, 0);
      rst = 1'b0;
      tick();
      feed(HALF - 1);
      chk("r_cnt", bus.acq_state, 0);
      feed(1);
      chk("r_wait", bus.acq_state, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
